// File: rtl/ysyx_25030081_seq_pkg.sv
// ysyx_25030081_seq_pkg: shared FSM state encoding and watchdog constants
package ysyx_25030081_seq_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        EXEC       = 3'd3,
        MEM_REQ    = 3'd4,
        MEM_WAIT   = 3'd5,
        WB         = 3'd6,
        STOP       = 3'd7
    } state_t;
    localparam int WDT_W = 8;
    localparam int WDT_LIMIT_DEF = 255;
endpackage

// File: rtl/ysyx_25030081_seq_if.sv
// ysyx_25030081_seq_if: instruction-fetch and load/store handshake bundle
interface ysyx_25030081_seq_if;
    logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
    modport master (
        output ifu_req_valid, lsu_req_valid, lsu_req_we,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
    );
    modport slave (
        input  ifu_req_valid, lsu_req_valid, lsu_req_we,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
    );
endinterface

// File: rtl/ysyx_25030081_wdt.sv
// ysyx_25030081_wdt: wait-state watchdog, flags when the count reaches LIMIT
module ysyx_25030081_wdt
    import ysyx_25030081_seq_pkg::*;
#(
    parameter int LIMIT = WDT_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    logic [WDT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (tick)  cnt <= cnt + WDT_W'(1);
    assign expired = cnt == WDT_W'(LIMIT);
endmodule

// File: rtl/ysyx_25030081_seq.sv
// ysyx_25030081_seq: multi-cycle core sequencer (fetch/exec/mem/writeback)
// with wait-state watchdog and sticky halt/fault status.
module ysyx_25030081_seq
    import ysyx_25030081_seq_pkg::*;
#(
    parameter int WDT_LIMIT = WDT_LIMIT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_25030081_seq_if.master         bus,
    input  logic                        reg_wr_in,
    input  logic                        mem_wr_in,
    input  logic                        mem_to_reg_in,
    input  logic                        halt_in,
    output logic                        inst_en,
    output logic                        rf_wen,
    output logic                        pc_en,
    output logic                        halted,
    output logic                        fault,
    output logic [2:0]                  state,
    output logic [31:0]                 inst_cnt
);
    state_t st, nxt;
    logic ifu_rv, lsu_rv, lsu_we, hs, wait_st, set_fault, set_halt, expired;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st       <= IDLE;
            halted   <= 1'b0;
            fault    <= 1'b0;
            inst_cnt <= '0;
        end else begin
            st       <= nxt;
            halted   <= halted | set_halt;
            fault    <= fault | set_fault;
            inst_cnt <= inst_cnt + 32'(pc_en);
        end
    always_comb begin
        nxt       = st;
        ifu_rv    = 1'b0;
        lsu_rv    = 1'b0;
        lsu_we    = 1'b0;
        inst_en   = 1'b0;
        rf_wen    = 1'b0;
        pc_en     = 1'b0;
        hs        = 1'b0;
        wait_st   = 1'b0;
        set_fault = 1'b0;
        set_halt  = 1'b0;
        case (st)
            IDLE: nxt = FETCH_REQ;
            FETCH_REQ: begin
                ifu_rv  = 1'b1;
                wait_st = 1'b1;
                hs      = bus.ifu_req_ready;
                nxt     = hs ? FETCH_WAIT : st;
            end
            FETCH_WAIT: begin
                wait_st   = 1'b1;
                hs        = bus.ifu_rsp_valid;
                inst_en   = hs & ~bus.ifu_rsp_err;
                set_fault = hs & bus.ifu_rsp_err;
                nxt       = hs ? (bus.ifu_rsp_err ? STOP : EXEC) : st;
            end
            EXEC: begin
                set_halt = halt_in;
                rf_wen   = ~halt_in & ~(mem_wr_in | mem_to_reg_in) & reg_wr_in;
                pc_en    = ~halt_in & ~(mem_wr_in | mem_to_reg_in);
                nxt      = halt_in ? STOP : (mem_wr_in | mem_to_reg_in) ? MEM_REQ : FETCH_REQ;
            end
            MEM_REQ: begin
                lsu_rv  = 1'b1;
                lsu_we  = mem_wr_in;
                wait_st = 1'b1;
                hs      = bus.lsu_req_ready;
                nxt     = hs ? MEM_WAIT : st;
            end
            MEM_WAIT: begin
                wait_st   = 1'b1;
                hs        = bus.lsu_rsp_valid;
                set_fault = hs & bus.lsu_rsp_err;
                nxt       = hs ? (bus.lsu_rsp_err ? STOP : WB) : st;
            end
            WB: begin
                rf_wen = reg_wr_in;
                pc_en  = 1'b1;
                nxt    = FETCH_REQ;
            end
            STOP: nxt = STOP;
        endcase
        // a handshake in the expiry cycle still wins
        if (wait_st & ~hs & expired) begin
            nxt       = STOP;
            set_fault = 1'b1;
        end
    end
    assign bus.ifu_req_valid = ifu_rv;
    assign bus.lsu_req_valid = lsu_rv;
    assign bus.lsu_req_we    = lsu_we;
    assign state             = st;
    ysyx_25030081_wdt #(.LIMIT(WDT_LIMIT)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (nxt != st),
        .tick    (wait_st & ~hs),
        .expired (expired)
    );
endmodule

// File: doc/ysyx_25030081_seq.md
YSYX_25030081_SEQ -- requirements
Module: ysyx_25030081_seq

Interface
REQ-001 SHALL: clk  in  1  sole clock, rising edge.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: ifu_req_valid  out  1  fetch request valid; ifu_req_ready  in  1  fetch request accepted.
REQ-004 SHALL: ifu_rsp_valid  in  1  instruction returned; ifu_rsp_err  in  1  fetch bus error, qualified by ifu_rsp_valid.
REQ-005 SHALL: inst_en  out  1  one-cycle load strobe for the instruction register.
REQ-006 SHALL: reg_wr_in, mem_wr_in, mem_to_reg_in, halt_in  in  1 each  decoder outputs, valid only in EXEC/MEM_*/WB.
REQ-007 SHALL: lsu_req_valid  out  1; lsu_req_we  out  1; lsu_req_ready  in  1; lsu_rsp_valid  in  1; lsu_rsp_err  in  1  data-memory handshake.
REQ-008 SHALL: rf_wen  out  1  gated register-file write; pc_en  out  1  PC update strobe.
REQ-009 SHALL: halted  out  1; fault  out  1  sticky status; state  out  3  debug view of FSM; inst_cnt  out  32  retired-instruction count.
REQ-010 SHALL: WDT_LIMIT, default 255, maximum wait-state cycles before fault.

Function
REQ-011 SHALL: states, encoded IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, STOP=7.
REQ-012 SHALL: IDLE -> FETCH_REQ unconditionally; all strobes and valids 0 in IDLE.
REQ-013 SHALL: FETCH_REQ drives ifu_req_valid=1 and moves to FETCH_WAIT on ifu_req_ready, else holds.
REQ-014 SHALL: FETCH_WAIT on ifu_rsp_valid & ~err -> inst_en=1 the same cycle and move to EXEC; on ifu_rsp_valid & err -> STOP, fault set.
REQ-015 SHALL: EXEC with halt_in -> STOP, halted set, no rf_wen, no pc_en, no count.
REQ-016 SHALL: EXEC with mem_wr_in|mem_to_reg_in -> MEM_REQ; otherwise rf_wen=reg_wr_in, pc_en=1, inst_cnt+1, -> FETCH_REQ.
REQ-017 SHALL: MEM_REQ drives lsu_req_valid=1, lsu_req_we=mem_wr_in; -> MEM_WAIT on lsu_req_ready.
REQ-018 SHALL: MEM_WAIT on lsu_rsp_valid & ~err -> WB; on lsu_rsp_valid & err -> STOP, fault set.
REQ-019 SHALL: WB drives rf_wen=reg_wr_in, pc_en=1, inst_cnt+1, -> FETCH_REQ; lsu_req_we=0 outside MEM_REQ.
REQ-020 SHALL: STOP is absorbing until reset; all strobes and valids 0.
REQ-021 SHALL: valid, strobe and we outputs are decoded combinationally from the state register and same-cycle inputs; no output is asserted in any state other than those listed.
REQ-022 SHALL: watchdog counter (8 bits) clears on every state change, increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT without that state's exit handshake.
REQ-023 SHALL: count==WDT_LIMIT with no handshake that cycle -> STOP, fault set; handshake in the same cycle wins over timeout.
REQ-024 SHALL: rsp_valid presented in a REQ state is ignored; req_ready presented in a WAIT state is ignored.
REQ-025 SHALL: inst_cnt wraps 0xFFFFFFFF -> 0 without side effect.
REQ-026 SHALL: at most one instruction in flight; inst_cnt increments exactly once per retired instruction.

Reset
REQ-027 SHALL: rst forces state=IDLE, watchdog=0, inst_cnt=0, halted=0, fault=0 immediately, independent of clk.
REQ-028 SHALL: reset asserted mid-handshake drops ifu_req_valid/lsu_req_valid in the same cycle; the first fetch request follows one IDLE cycle after release.

Structure
REQ-029 SHALL: state encodings and WDT_LIMIT default live in the shared package used by the core's decoder.
REQ-030 SHALL: watchdog is a sub-module ysyx_25030081_wdt (inputs clear, tick; output expired).

Verification
REQ-031 SHALL: release reset, ifu_req_ready=1, rsp after 2 cycles, decoder addi (reg_wr_in=1) -> state 0,1,2,2,3,1; rf_wen and pc_en high only in EXEC cycle; inst_cnt=1.
REQ-032 SHALL: load (mem_to_reg_in=1, reg_wr_in=1), lsu ready after 3 cycles, rsp after 1 -> lsu_req_valid high 4 cycles, lsu_req_we=0, rf_wen only in WB, inst_cnt=1.
REQ-033 SHALL: store (mem_wr_in=1, reg_wr_in=0) -> lsu_req_we=1 during MEM_REQ, rf_wen never asserted, pc_en once in WB.
REQ-034 SHALL: ifu_req_ready held 0 -> state=STOP, fault=1 after 256 FETCH_REQ cycles; ready asserted on the 256th cycle -> FETCH_WAIT, fault=0.
REQ-035 SHALL: halt_in=1 in EXEC -> STOP, halted=1, inst_cnt unchanged; later lsu_rsp_err/ifu inputs cause no change until reset.
REQ-036 SHALL: rst pulsed while in MEM_WAIT -> lsu_req_valid=0, state=0, inst_cnt=0 same cycle; fresh fetch after release; preload inst_cnt 0xFFFFFFFF via force then retire -> 0.
